// File: rtl/bus_pkg.sv
// Shared bus encodings and the split-target memory state type.
package bus_pkg;

    localparam logic BUS_RW_READ  = 1'b0;
    localparam logic BUS_RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_WR_ACK   = 3'd2,
        ST_RD_SPLIT = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_REQ   = 3'd5,
        ST_RD_SEND  = 3'd6
    } split_mem_state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM: synchronous write, registered read (read-before-write).
module sp_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage is deliberately unreset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/split_mem_target.sv
// Slow byte memory behind the split-target port: in-place writes, split reads
// that release the bus and re-arbitrate via req/grant after READ_LATENCY cycles.
module split_mem_target
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_in,
    input  logic        addr_in_valid,
    input  logic        rw,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    input  logic        grant,
    output logic        req,
    output logic [7:0]  data_out,
    output logic        data_out_valid,
    output logic        ack,
    output logic        split_ack,
    output logic        ready
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(READ_LATENCY + 1);

    split_mem_state_t      state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     rd_buf;
    logic [DATA_W-1:0]     ram_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic                  ram_we_c;
    logic                  unused_addr_c;

    assign unused_addr_c = ^addr_in[15:ADDR_WIDTH];

    // In IDLE the RAM sees the live address so a same-cycle write commits at once.
    always_comb begin
        ram_addr_c = addr_q;
        ram_we_c   = 1'b0;
        if (state == ST_IDLE) begin
            ram_addr_c = addr_in[ADDR_WIDTH-1:0];
            ram_we_c   = addr_in_valid && (rw == BUS_RW_WRITE) && data_in_valid;
        end else if (state == ST_WR_DATA) begin
            ram_we_c   = data_in_valid;
        end
    end

    sp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            cnt            <= '0;
            rd_buf         <= '0;
            req            <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            ack            <= 1'b0;
            split_ack      <= 1'b0;
            ready          <= 1'b1;
        end else begin
            ack            <= 1'b0;
            split_ack      <= 1'b0;
            data_out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (addr_in_valid) begin
                        addr_q <= addr_in[ADDR_WIDTH-1:0];
                        ready  <= 1'b0;
                        if (rw == BUS_RW_WRITE) begin
                            state <= data_in_valid ? ST_WR_ACK : ST_WR_DATA;
                        end else begin
                            state <= ST_RD_SPLIT;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (data_in_valid) begin
                        state <= ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    ack   <= 1'b1;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_RD_SPLIT: begin
                    split_ack <= 1'b1;
                    cnt       <= CNT_W'(READ_LATENCY - 1);
                    state     <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        rd_buf <= ram_rdata;
                        state  <= ST_RD_REQ;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RD_REQ: begin
                    if (grant) begin
                        req   <= 1'b0;
                        state <= ST_RD_SEND;
                    end else begin
                        req <= 1'b1;
                    end
                end
                ST_RD_SEND: begin
                    data_out_valid <= 1'b1;
                    ack            <= 1'b1;
                    data_out       <= rd_buf;
                    ready          <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_mem_target.sv
// Directed bench for split_mem_target with a read-data scoreboard queue.
module tb_split_mem_target;

    localparam int unsigned RL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_in;
    logic        addr_in_valid;
    logic        rw;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        grant;
    logic        req;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        ack;
    logic        split_ack;
    logic        ready;

    int total = 0;
    int bad   = 0;
    int n_ack   = 0;
    int n_split = 0;
    int n_dov   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    split_mem_target #(
        .ADDR_WIDTH   (12),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr_in        (addr_in),
        .addr_in_valid  (addr_in_valid),
        .rw             (rw),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .grant          (grant),
        .req            (req),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .ack            (ack),
        .split_ack      (split_ack),
        .ready          (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Pulse counters and scoreboard pop on every returned read byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack) n_ack++;
            if (split_ack) n_split++;
            if (data_out_valid) begin
                n_dov++;
                if (exp_q.size() == 0) begin
                    chk("dov_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("sb_rd_data", 32'(data_out), 32'(mon_exp));
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit imm);
        addr_in = a; rw = 1'b1; addr_in_valid = 1'b1;
        if (imm) begin
            data_in = d; data_in_valid = 1'b1;
        end
        step();
        addr_in_valid = 1'b0;
        if (!imm) begin
            data_in = d; data_in_valid = 1'b1;
            sample();
            chk("wr_ready_low", 32'(ready), 32'd0);
            step();
        end
        data_in_valid = 1'b0;
        sample();
        chk("wr_ack_early", 32'(ack), 32'd0);
        step();
        sample();
        chk("wr_ack", 32'(ack), 32'd1);
        chk("wr_ready", 32'(ready), 32'd1);
        step();
        sample();
        chk("wr_ack_end", 32'(ack), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] e, input bit early_grant, input bit busy);
        int n;
        bit seen;
        addr_in = a; rw = 1'b0; addr_in_valid = 1'b1;
        step();
        addr_in_valid = 1'b0;
        sample();
        chk("rd_split_early", 32'(split_ack), 32'd0);
        chk("rd_ready_low", 32'(ready), 32'd0);
        step();
        sample();
        chk("split_ack", 32'(split_ack), 32'd1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (early_grant) grant = (n >= 2 && n <= 6);
            if (busy) begin
                addr_in = 16'h0123; rw = 1'b1; data_in = 8'hEE;
                addr_in_valid = (n == 3);
                data_in_valid = (n == 3);
            end
            sample();
            if (req) seen = 1'b1;
        end
        addr_in_valid = 1'b0;
        data_in_valid = 1'b0;
        chk("req_latency", 32'(n), 32'(RL + 1));
        exp_q.push_back(e);
        grant = 1'b1;
        step();
        sample();
        chk("req_drop", 32'(req), 32'd0);
        chk("dov_before", 32'(data_out_valid), 32'd0);
        step();
        sample();
        chk("rd_ack", 32'(ack), 32'd1);
        chk("rd_dov", 32'(data_out_valid), 32'd1);
        chk("rd_data_out", 32'(data_out), 32'(e));
        step();
        grant = 1'b0;
        sample();
        chk("rd_dov_end", 32'(data_out_valid), 32'd0);
        chk("rd_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ack_snap;
        int dov_snap;
        rst_n = 1'b0; addr_in = '0; addr_in_valid = 1'b0; rw = 1'b0;
        data_in = '0; data_in_valid = 1'b0; grant = 1'b0;
        repeat (3) step();
        sample();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_dov", 32'(data_out_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_split_ack", 32'(split_ack), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_ack_cnt", 32'(n_ack), 32'd0);
        chk("idle_split_cnt", 32'(n_split), 32'd0);
        chk("idle_dov_cnt", 32'(n_dov), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);

        do_write(16'h0123, 8'hA5, 1'b0);
        do_read(16'h0123, 8'hA5, 1'b0, 1'b0);
        repeat (3) step();
        chk("data_out_hold", 32'(data_out), 32'hA5);

        do_write(16'hFFFF, 8'h3C, 1'b0);
        do_read(16'h0FFF, 8'h3C, 1'b1, 1'b0);
        do_write(16'h0456, 8'h5A, 1'b1);
        do_read(16'h0123, 8'hA5, 1'b0, 1'b1);

        // Reset while req is pending: the read must vanish.
        addr_in = 16'h0456; rw = 1'b0; addr_in_valid = 1'b1;
        step();
        addr_in_valid = 1'b0;
        n = 0;
        while (req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("rst_test_req_seen", 32'(req), 32'd1);
        sample();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(req), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        step();
        rst_n = 1'b1;
        ack_snap = n_ack;
        dov_snap = n_dov;
        repeat (15) step();
        chk("post_rst_ack", 32'(n_ack), 32'(ack_snap));
        chk("post_rst_dov", 32'(n_dov), 32'(dov_snap));
        chk("post_rst_req", 32'(req), 32'd0);

        do_read(16'h0123, 8'hA5, 1'b0, 1'b0);
        do_read(16'h0456, 8'h5A, 1'b0, 1'b0);
        repeat (2) step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("total_dov", 32'(n_dov), 32'd5);
        chk("total_split", 32'(n_split), 32'd6);
        chk("total_ack", 32'(n_ack), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
